// File: rtl/fdct_transpose_buf.sv
// 8x8 transpose buffer controller between the FDCT row and column passes.
// Writes a raster block into one RAM bank, then reads it back column-major into a 2-deep output FIFO.
module fdct_transpose_buf #(
    parameter int DATA_W    = 8,
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              ram_we,
    output logic [6:0]        ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               bank_q, bank_d;
    logic [5:0]         wcnt_q, wcnt_d;
    logic [6:0]         rcnt_q, rcnt_d;
    logic               inflight_q, inflight_d;
    logic               rd_last_q, rd_last_d;
    logic               in_ready_q, in_ready_d;
    logic [DATA_W-1:0]  fifo_data_q [2];
    logic [DATA_W-1:0]  fifo_data_d [2];
    logic [1:0]         fifo_last_q, fifo_last_d;
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [1:0]         count_q, count_d;

    logic               wr_fire, pop, push, issue, drain_done;
    logic [2:0]         occ;
    logic [6:0]         rd_addr;

    assign wr_fire    = in_valid && in_ready_q;
    assign pop        = (count_q != 2'd0) && out_ready;
    assign push       = inflight_q;
    // Counting the same-cycle pop lets reads stream at one per cycle without overflowing.
    assign occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == DRAIN) && !rcnt_q[6] && (occ < 3'd2);
    assign drain_done = (state_q == DRAIN) && rcnt_q[6] && !inflight_q;
    assign rd_addr    = TRANSPOSE ? {bank_q, rcnt_q[2:0], rcnt_q[5:3]} : {bank_q, rcnt_q[5:0]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (wr_fire && wcnt_q == 6'd63) state_d = DRAIN;
            DRAIN:   if (drain_done)                 state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Output logic: RAM port is combinational from the handshake / read issue
    always_comb begin
        ram_we   = wr_fire;
        ram_din  = wr_fire ? in_data : '0;
        ram_addr = 7'd0;
        if (wr_fire)    ram_addr = {bank_q, wcnt_q};
        else if (issue) ram_addr = rd_addr;
    end

    always_comb begin
        wcnt_d      = wr_fire ? wcnt_q + 6'd1 : wcnt_q;
        rcnt_d      = drain_done ? 7'd0 : (issue ? rcnt_q + 7'd1 : rcnt_q);
        bank_d      = drain_done ? ~bank_q : bank_q;
        inflight_d  = issue;
        rd_last_d   = issue && (rcnt_q == 7'd63);
        in_ready_d  = (state_d == FILL);
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        if (push) begin
            fifo_data_d[wptr_q] = ram_dout;
            fifo_last_d[wptr_q] = rd_last_q;
        end
        wptr_d  = wptr_q ^ push;
        rptr_d  = rptr_q ^ pop;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q         <= 1'b0;
            wcnt_q         <= '0;
            rcnt_q         <= '0;
            inflight_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            in_ready_q     <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            count_q        <= '0;
        end else begin
            bank_q      <= bank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            inflight_q  <= inflight_d;
            rd_last_q   <= rd_last_d;
            in_ready_q  <= in_ready_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? fifo_data_q[rptr_q] : '0;
    assign out_last  = out_valid && fifo_last_q[rptr_q];

endmodule

// File: tb/tb_fdct_transpose_buf.sv
// Bench for fdct_transpose_buf: a transposing and a raster instance share one stimulus stream,
// each with its own behavioural 128x8 RAM.
module tb_fdct_transpose_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b1;

    logic       in_ready1, out_valid1, out_last1, ram_we1;
    logic [7:0] out_data1, ram_din1, ram_dout1;
    logic [6:0] ram_addr1;
    logic       in_ready0, out_valid0, out_last0, ram_we0;
    logic [7:0] out_data0, ram_din0, ram_dout0;
    logic [6:0] ram_addr0;

    always #5 clk = ~clk;

    fdct_transpose_buf #(.DATA_W(8), .TRANSPOSE(1'b1)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
        .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(ram_dout1));

    fdct_transpose_buf #(.DATA_W(8), .TRANSPOSE(1'b0)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
        .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_dout(ram_dout0));

    logic [7:0] mem1 [128];
    logic [7:0] mem0 [128];
    always @(posedge clk) begin
        if (ram_we1) mem1[ram_addr1] <= ram_din1;
        ram_dout1 <= mem1[ram_addr1];
        if (ram_we0) mem0[ram_addr0] <= ram_din0;
        ram_dout0 <= mem0[ram_addr0];
    end

    int nchecks = 0;
    int nerr    = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: collect popped samples and write addresses, flag protocol violations
    logic [7:0] q1d[$], q0d[$];
    logic       q1l[$], q0l[$];
    longint     q1t[$];
    int         wq[$];
    int         viol_we = 0, viol_st = 0;
    logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = 8'd0;
    logic       stall_en = 1'b0;

    always @(negedge clk) begin
        if (out_valid1 && out_ready) begin q1d.push_back(out_data1); q1l.push_back(out_last1); q1t.push_back($time); end
        if (out_valid0 && out_ready) begin q0d.push_back(out_data0); q0l.push_back(out_last0); end
        if (ram_we1) wq.push_back(int'(ram_addr1));
        if (ram_we1 != (in_valid && in_ready1)) viol_we++;
        if (ram_we0 != (in_valid && in_ready0)) viol_we++;
        if (pv && !pr && !rst && (!out_valid1 || out_data1 != pd || out_last1 != pl)) viol_st++;
        pv = out_valid1 && !rst; pr = out_ready; pd = out_data1; pl = out_last1;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    longint hs_t [8];

    task automatic send_block(input int base, input bit gap, input int idx);
        for (int i = 0; i < 64; i++) begin
            int t;
            in_valid = 1'b1;
            in_data  = 8'(base + i);
            t = 0;
            @(negedge clk);
            while (!in_ready1 && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            if (i == 63) hs_t[idx] = $time;
            #1;
            if (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int idx, input int base, input bit bank, input bit stall, input bit lat);
        int t, ed, el, ea, er, erl;
        logic [7:0] d, expd;
        logic       l;
        longint     t0;
        stall_en = stall;
        t = 0;
        while (q1d.size() < 64 && t < 5000) begin @(negedge clk); t++; end
        if (q1d.size() < 64) begin check("out_timeout", q1d.size(), 64); return; end
        ed = 0; el = 0; ea = 0; er = 0; erl = 0;
        t0 = q1t[0];
        for (int k = 0; k < 64; k++) begin
            d = q1d.pop_front(); l = q1l.pop_front(); void'(q1t.pop_front());
            expd = 8'(base + (k % 8) * 8 + k / 8);
            if (d != expd) begin
                if (ed == 0) $display("FAIL data blk%0d[%0d]: got %0d expected %0d", idx, k, d, expd);
                ed++;
            end
            if (l != (k == 63)) el++;
            if (q0d.size() > 0) begin
                d = q0d.pop_front(); l = q0l.pop_front();
                if (d != 8'(base + k)) er++;
                if (l != (k == 63)) erl++;
            end else er++;
            if (wq.size() > 0) begin
                if (wq.pop_front() != int'(bank) * 64 + k) ea++;
            end else ea++;
        end
        check($sformatf("blk%0d transposed data errs", idx), ed, 0);
        check($sformatf("blk%0d out_last errs", idx), el, 0);
        check($sformatf("blk%0d write addr errs", idx), ea, 0);
        check($sformatf("blk%0d raster data errs", idx), er, 0);
        check($sformatf("blk%0d raster last errs", idx), erl, 0);
        check($sformatf("blk%0d ram_we vs handshake", idx), viol_we, 0);
        check($sformatf("blk%0d stall stability", idx), viol_st, 0);
        viol_we = 0; viol_st = 0;
        if (lat) check($sformatf("blk%0d first out_valid time", idx), t0, hs_t[idx] + 25);
        stall_en = 1'b0;
    endtask

    typedef struct {
        int base;
        bit gap;
        bit stall;
        bit bank;
        bit lat;
    } vec_t;
    vec_t tbl [5];

    initial begin
        tbl[0] = '{base: 0,   gap: 1'b0, stall: 1'b0, bank: 1'b0, lat: 1'b1};
        tbl[1] = '{base: 0,   gap: 1'b0, stall: 1'b1, bank: 1'b1, lat: 1'b0};
        tbl[2] = '{base: 0,   gap: 1'b1, stall: 1'b0, bank: 1'b0, lat: 1'b0};
        tbl[3] = '{base: 64,  gap: 1'b0, stall: 1'b0, bank: 1'b1, lat: 1'b0};
        tbl[4] = '{base: 128, gap: 1'b0, stall: 1'b0, bank: 1'b0, lat: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready1, 0);
        check("reset out_valid", out_valid1, 0);
        check("reset out_last", out_last1, 0);
        check("reset out_data", out_data1, 0);
        check("reset ram_we", ram_we1, 0);
        check("reset ram_addr", ram_addr1, 0);
        check("reset ram_din", ram_din1, 0);
        rst = 1'b0;
        #1 check("in_ready before first edge", in_ready1, 0);
        @(posedge clk); #1;
        check("in_ready after first edge", in_ready1, 1);

        fork
            for (int b = 0; b < 5; b++) send_block(tbl[b].base, tbl[b].gap, b);
            for (int b = 0; b < 5; b++) collect(b, tbl[b].base, tbl[b].bank, tbl[b].stall, tbl[b].lat);
        join

        // Reset in the middle of draining a block that would otherwise sit in bank 1
        fork
            send_block(200, 1'b0, 5);
            begin
                int t;
                t = 0;
                while (q1d.size() < 20 && t < 3000) begin @(negedge clk); t++; end
                check("20 outputs before reset", q1d.size() >= 20, 1);
            end
        join
        #1 rst = 1'b1;
        #1;
        check("mid rst out_valid", out_valid1, 0);
        check("mid rst in_ready", in_ready1, 0);
        @(posedge clk); #1;
        check("mid rst in_ready held", in_ready1, 0);
        rst = 1'b0;
        @(negedge clk);
        q1d.delete(); q1l.delete(); q1t.delete(); q0d.delete(); q0l.delete(); wq.delete();
        viol_we = 0; viol_st = 0;
        fork
            send_block(200, 1'b0, 6);
            collect(6, 200, 1'b0, 1'b0, 1'b1);
        join

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
